dynamics_envelope: RTL and testbench

Multi-channel envelope shaper that sits between the note sequencer and the codec, replacing the single on/off dynamics switch.
- Runs an ADSR gain state machine, advanced once per codec frame (new_frame).
- Scales all NUM_CH PCM channels by the current gain and presents registered samples to the AC97 interface.
- Parametrised in sample width, gain resolution, channel count and envelope rates.

---
 rtl/dynamics_pkg.sv | 25 ++
 rtl/env_scale.sv | 28 ++
 rtl/dynamics_envelope.sv | 176 +++++++++++++++++
 tb/tb_dynamics_envelope.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dynamics_pkg.sv
// Shared types and default rates for the envelope shaper.
package dynamics_pkg;

    localparam int ENV_STATE_W = 3;

    typedef enum logic [ENV_STATE_W-1:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam int DEF_GAIN_W       = 8;
    localparam int DEF_ATTACK_STEP  = 16;
    localparam int DEF_DECAY_STEP   = 4;
    localparam int DEF_SUSTAIN_LVL  = 192;
    localparam int DEF_RELEASE_STEP = 2;

    // States in which a note is sounding and note_end may release it.
    function automatic logic note_held(env_state_t s);
        return (s == ATTACK) || (s == DECAY) || (s == SUSTAIN);
    endfunction

endpackage

// File: rtl/env_scale.sv
// Single-channel gain stage: signed sample times unsigned gain, floored back to W bits.
module env_scale #(
    parameter int W      = 16,
    parameter int GAIN_W = 8
) (
    input  logic [W-1:0]      sample,
    input  logic [GAIN_W-1:0] gain,
    input  logic              bypass,
    output logic [W-1:0]      scaled
);

    localparam int PW = W + GAIN_W + 1;

    logic signed [PW-1:0] sample_x;
    logic signed [PW-1:0] gain_x;
    logic signed [PW-1:0] prod;
    logic                 unused_prod_bits;

    assign sample_x = {{(GAIN_W+1){sample[W-1]}}, sample};
    assign gain_x   = {{(W+1){1'b0}}, gain};
    assign prod     = sample_x * gain_x;

    // Taking the bit window above GAIN_W is the arithmetic shift, so negatives floor.
    assign scaled = bypass ? sample : prod[GAIN_W +: W];

    assign unused_prod_bits = ^{prod[PW-1], prod[GAIN_W-1:0]};

endmodule

// File: rtl/dynamics_envelope.sv
// ADSR envelope shaper applying one shared gain to NUM_CH PCM channels per codec frame.
// Optional peak-hold meter on the output is enabled with `define PEAK_METER_EN.
module dynamics_envelope
    import dynamics_pkg::*;
#(
    parameter int W            = 16,
    parameter int NUM_CH       = 2,
    parameter int GAIN_W       = DEF_GAIN_W,
    parameter int ATTACK_STEP  = DEF_ATTACK_STEP,
    parameter int DECAY_STEP   = DEF_DECAY_STEP,
    parameter int SUSTAIN_LVL  = DEF_SUSTAIN_LVL,
    parameter int RELEASE_STEP = DEF_RELEASE_STEP
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_frame,
    input  logic                   note_start,
    input  logic                   note_end,
    input  logic                   dynamics_en,
    input  logic [NUM_CH*W-1:0]    sample_in,
    output logic [NUM_CH*W-1:0]    sample_out,
    output logic                   out_valid,
    output logic [GAIN_W-1:0]      gain,
    output logic [ENV_STATE_W-1:0] env_state
`ifdef PEAK_METER_EN
    ,
    output logic [W-1:0]           peak
`endif
);

    localparam int STAGES = 1;

    localparam logic [GAIN_W:0] GMAX = {1'b0, {GAIN_W{1'b1}}};
    localparam logic [GAIN_W:0] ATK  = (GAIN_W+1)'(ATTACK_STEP);
    localparam logic [GAIN_W:0] DEC  = (GAIN_W+1)'(DECAY_STEP);
    localparam logic [GAIN_W:0] SUS  = (GAIN_W+1)'(SUSTAIN_LVL);
    localparam logic [GAIN_W:0] REL  = (GAIN_W+1)'(RELEASE_STEP);

    env_state_t               state_q, state_d;
    logic [GAIN_W-1:0]        gain_q, gain_d;
    logic [GAIN_W:0]          gain_up, gain_dec, gain_rel;
    logic [STAGES:0]          vld_pipe;
    logic [NUM_CH-1:0][W-1:0] scaled;

    // ------------------------------------------------------------------
    // Envelope FSM and gain counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gain_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    assign gain_up  = {1'b0, gain_q} + ATK;
    assign gain_dec = {1'b0, gain_q} - DEC;
    assign gain_rel = {1'b0, gain_q} - REL;

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        // The step is driven by the state held before this edge; a borrow
        // into the extra MSB means the subtraction went below zero.
        if (new_frame) begin
            case (state_q)
                IDLE: gain_d = '0;
                ATTACK: begin
                    if (gain_up >= GMAX) begin
                        gain_d  = GMAX[GAIN_W-1:0];
                        state_d = DECAY;
                    end else begin
                        gain_d = gain_up[GAIN_W-1:0];
                    end
                end
                DECAY: begin
                    if (gain_dec[GAIN_W] || (gain_dec <= SUS)) begin
                        gain_d  = SUS[GAIN_W-1:0];
                        state_d = SUSTAIN;
                    end else begin
                        gain_d = gain_dec[GAIN_W-1:0];
                    end
                end
                RELEASE: begin
                    if (gain_rel[GAIN_W] || (gain_rel == '0)) begin
                        gain_d  = '0;
                        state_d = IDLE;
                    end else begin
                        gain_d = gain_rel[GAIN_W-1:0];
                    end
                end
                default: ;
            endcase
        end
        // Note events override any level-reached transition; gain is not zeroed.
        if (note_start)
            state_d = ATTACK;
        else if (note_end && note_held(state_q))
            state_d = RELEASE;
    end

    assign gain      = gain_q;
    assign env_state = state_q;

    // ------------------------------------------------------------------
    // Per-channel datapath, using the gain held before this frame's step
    // ------------------------------------------------------------------
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        env_scale #(
            .W      (W),
            .GAIN_W (GAIN_W)
        ) u_scale (
            .sample (sample_in[ch*W +: W]),
            .gain   (gain_q),
            .bypass (!dynamics_en),
            .scaled (scaled[ch])
        );
    end

    assign vld_pipe[0] = new_frame;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe[STAGES:1] <= '0;
            sample_out         <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (new_frame)
                sample_out <= scaled;
        end
    end

    assign out_valid = vld_pipe[STAGES];

`ifdef PEAK_METER_EN
    logic [NUM_CH-1:0][W-1:0] mag;
    logic [W-1:0]             frame_max;
    logic [7:0]               decay_cnt;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_mag
        logic [W-1:0] so;
        assign so = sample_out[ch*W +: W];
        // The most negative code has no positive twin, so it pins at full scale.
        assign mag[ch] = !so[W-1]                    ? so :
                         (so == {1'b1, {(W-1){1'b0}}}) ? {1'b0, {(W-1){1'b1}}} :
                                                         -so;
    end

    always_comb begin
        frame_max = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (mag[c] > frame_max)
                frame_max = mag[c];
    end

    // A fresh load restarts the 256-frame halving interval.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak      <= '0;
            decay_cnt <= '0;
        end else if (out_valid) begin
            if (frame_max > peak) begin
                peak      <= frame_max;
                decay_cnt <= '0;
            end else begin
                decay_cnt <= decay_cnt + 8'd1;
                if (decay_cnt == 8'hFF)
                    peak <= peak >> 1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dynamics_envelope.sv
// Scoreboard bench for dynamics_envelope: reference envelope model plus expected-sample queue.
module tb_dynamics_envelope;

    localparam int W      = 16;
    localparam int NUM_CH = 2;
    localparam int GAIN_W = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                new_frame = 1'b0;
    logic                note_start = 1'b0;
    logic                note_end = 1'b0;
    logic                dynamics_en = 1'b1;
    logic [NUM_CH*W-1:0] sample_in = '0;
    logic [NUM_CH*W-1:0] sample_out;
    logic                out_valid;
    logic [GAIN_W-1:0]   gain;
    logic [2:0]          env_state;
`ifdef PEAK_METER_EN
    logic [W-1:0]        peak;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int m_gain = 0;
    int m_state = 0;
    logic [NUM_CH*W-1:0] sb[$];

    always #5 clk = ~clk;

    dynamics_envelope #(.W(W), .NUM_CH(NUM_CH), .GAIN_W(GAIN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .new_frame   (new_frame),
        .note_start  (note_start),
        .note_end    (note_end),
        .dynamics_en (dynamics_en),
        .sample_in   (sample_in),
        .sample_out  (sample_out),
        .out_valid   (out_valid),
        .gain        (gain),
        .env_state   (env_state)
`ifdef PEAK_METER_EN
        ,
        .peak        (peak)
`endif
    );

    // One clock: predict from the inputs now applied, advance, then score.
    task automatic step();
        bit fv;
        int g;
        int ns;
        logic [NUM_CH*W-1:0] e;
        fv = new_frame && !reset;
        e = '0;
        if (reset) begin
            m_gain = 0; m_state = 0; sb.delete();
        end else begin
            g = m_gain; ns = m_state;
            if (fv) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    int s;
                    int p;
                    s = int'($signed(sample_in[c*W +: W]));
                    p = dynamics_en ? ((s * m_gain) >>> GAIN_W) : s;
                    e[c*W +: W] = p[W-1:0];
                end
                sb.push_back(e);
                case (m_state)
                    0: g = 0;
                    1: begin g = (m_gain + 16 > 255) ? 255 : m_gain + 16; if (g == 255) ns = 2; end
                    2: begin g = (m_gain - 4 < 192) ? 192 : m_gain - 4;   if (g == 192) ns = 3; end
                    4: begin g = (m_gain - 2 < 0) ? 0 : m_gain - 2;       if (g == 0) ns = 0; end
                    default: ;
                endcase
            end
            if (note_start) ns = 1;
            else if (note_end && m_state >= 1 && m_state <= 3) ns = 4;
            m_gain = g; m_state = ns;
        end
        @(posedge clk); #1;
        n_chk++;
        if (out_valid !== fv) begin
            n_fail++; $display("FAIL out_valid: got %b want %b", out_valid, fv);
        end
        if (out_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (sample_out !== e) begin
                n_fail++; $display("FAIL sample_out: got %h want %h", sample_out, e);
            end
        end
        n_chk++;
        if (gain !== GAIN_W'(m_gain) || env_state !== 3'(m_state)) begin
            n_fail++;
            $display("FAIL envelope: got gain %0d state %0d want gain %0d state %0d",
                     gain, env_state, m_gain, m_state);
        end
    endtask

    task automatic frame(int gap);
        new_frame = 1'b1; step(); new_frame = 1'b0;
        repeat (gap - 1) step();
    endtask

    task automatic pulse(bit s, bit e);
        note_start = s; note_end = e; step(); note_start = 1'b0; note_end = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step(); reset = 1'b0;
        n_chk++;
        if (gain !== 8'd0 || env_state !== 3'd0 || sample_out !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got gain %0d state %0d out %h vld %b want 0 0 0 0",
                     gain, env_state, sample_out, out_valid);
        end
    endtask

    task automatic test_adsr_scaling();
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            sample_in = {$urandom_range(0, 65535), $urandom_range(0, 65535)};
            sample_in = sample_in & {NUM_CH{16'hFFFF}};
            frame(4);
        end
        n_chk++;
        if (gain !== 8'd240 || env_state !== 3'd1) begin
            n_fail++; $display("FAIL attack_15: got gain %0d state %0d want 240 1", gain, env_state);
        end
        frame(4);
        n_chk++;
        if (gain !== 8'd255 || env_state !== 3'd2) begin
            n_fail++; $display("FAIL attack_peak: got gain %0d state %0d want 255 2", gain, env_state);
        end
        sample_in = {16'h8000, 16'h4000};
        frame(4);
        n_chk++;
        if (sample_out[15:0] !== 16'd16320 || sample_out[31:16] !== 16'h8080) begin
            n_fail++; $display("FAIL scale_255: got %h want 8080_3fc0", sample_out);
        end
        for (int i = 0; i < 15; i++) frame(4);
        n_chk++;
        if (gain !== 8'd192 || env_state !== 3'd3) begin
            n_fail++; $display("FAIL decay_end: got gain %0d state %0d want 192 3", gain, env_state);
        end
    endtask

    task automatic test_bypass();
        dynamics_en = 1'b0; sample_in = {16'h1234, 16'h1234};
        frame(4);
        n_chk++;
        if (sample_out !== 32'h1234_1234) begin
            n_fail++; $display("FAIL bypass: got %h want 12341234", sample_out);
        end
        dynamics_en = 1'b1;
        frame(4);
        n_chk++;
        if (sample_out !== {16'd3495, 16'd3495}) begin
            n_fail++; $display("FAIL reenable_192: got %h want %h", sample_out, {16'd3495, 16'd3495});
        end
    endtask

    task automatic test_release();
        bit saw_floor;
        saw_floor = 1'b0;
        sample_in = {16'h7FFF, 16'h0100};
        pulse(1'b0, 1'b1);
        n_chk++;
        if (env_state !== 3'd4) begin
            n_fail++; $display("FAIL release_enter: got state %0d want 4", env_state);
        end
        for (int i = 0; i < 95; i++) begin
            if (m_gain == 128) begin
                sample_in = {16'h0000, 16'hFFFF};
                frame(4);
                saw_floor = 1'b1;
                n_chk++;
                if (sample_out[15:0] !== 16'hFFFF) begin
                    n_fail++; $display("FAIL floor_128: got %h want ffff", sample_out[15:0]);
                end
            end else begin
                frame(4);
            end
        end
        n_chk++;
        if (!saw_floor || gain !== 8'd2 || env_state !== 3'd4) begin
            n_fail++; $display("FAIL release_95: got gain %0d state %0d floor %b want 2 4 1", gain, env_state, saw_floor);
        end
        frame(4);
        n_chk++;
        if (gain !== 8'd0 || env_state !== 3'd0) begin
            n_fail++; $display("FAIL release_end: got gain %0d state %0d want 0 0", gain, env_state);
        end
    endtask

    task automatic test_corners();
        pulse(1'b0, 1'b1);
        n_chk++;
        if (env_state !== 3'd0) begin
            n_fail++; $display("FAIL end_in_idle: got state %0d want 0", env_state);
        end
        pulse(1'b1, 1'b1);
        n_chk++;
        if (env_state !== 3'd1) begin
            n_fail++; $display("FAIL start_end_same: got state %0d want 1", env_state);
        end
        for (int i = 0; i < 7; i++) frame(1);
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) frame(1);
        pulse(1'b0, 1'b1);
        n_chk++;
        if (gain !== 8'd100 || env_state !== 3'd4) begin
            n_fail++; $display("FAIL release_100: got gain %0d state %0d want 100 4", gain, env_state);
        end
        pulse(1'b1, 1'b0);
        frame(2);
        n_chk++;
        if (gain !== 8'd116 || env_state !== 3'd1) begin
            n_fail++; $display("FAIL retrigger: got gain %0d state %0d want 116 1", gain, env_state);
        end
    endtask

    task automatic test_back_to_back();
        sample_in = {16'hC000, 16'h2345};
        for (int i = 0; i < 5; i++) frame(1);
        step();
        n_chk++;
        if (gain !== 8'd196 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL back_to_back: got gain %0d vld %b want 196 0", gain, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        sample_in = {16'h1000, 16'h2000};
        new_frame = 1'b1; step(); new_frame = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (gain !== 8'd0 || env_state !== 3'd0 || sample_out !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got gain %0d state %0d out %h vld %b want 0 0 0 0",
                     gain, env_state, sample_out, out_valid);
        end
        step();
        reset = 1'b0;
        step();
    endtask

`ifdef PEAK_METER_EN
    task automatic test_peak();
        reset = 1'b1; step(); reset = 1'b0;
        sample_in = '0;
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) frame(1);
        sample_in = {16'h0000, 16'h4000};
        new_frame = 1'b1; step();
        sample_in = '0;
        step();
        n_chk++;
        if (peak !== 16'd16320) begin
            n_fail++; $display("FAIL peak_load: got %0d want 16320", peak);
        end
        repeat (255) step();
        n_chk++;
        if (peak !== 16'd16320) begin
            n_fail++; $display("FAIL peak_hold: got %0d want 16320", peak);
        end
        new_frame = 1'b0; step();
        n_chk++;
        if (peak !== 16'd8160) begin
            n_fail++; $display("FAIL peak_decay: got %0d want 8160", peak);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_adsr_scaling();
        test_bypass();
        test_release();
        test_corners();
        test_back_to_back();
        test_reset_mid();
`ifdef PEAK_METER_EN
        test_peak();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
